word_accum_rx: RTL and testbench

Receive-side accumulator for the 8-bit word stream produced by the lab datapath's registered counter/register output. It accepts words over a valid/ready handshake, sums a fixed-size block of COUNT words, and presents the block sum plus an overflow flag on a second valid/ready port. It sits downstream of the 8-bit register/counter path and feeds the 16-bit mux/result stage.

---
 rtl/acc_pkg.sv | 21 ++
 rtl/word_accum_rx_if.sv | 29 ++
 rtl/acc_add.sv | 28 ++
 rtl/word_accum_rx.sv | 106 ++++++++++
 tb/tb_word_accum_rx.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// Shared types and constants for the word_accum_rx block-sum receiver.
package acc_pkg;

    // Word width of the incoming stream.
    localparam int DW = 8;

    // Width of the per-block word counter; COUNT is limited to 255, so 8 bits hold it.
    localparam int CW = 8;

    // Default configuration: words per block and sum width.
    localparam int COUNT_DEF = 8;
    localparam int SW_DEF    = 12;

    // Block FSM: accept first word, accumulate the rest, present the sum.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/word_accum_rx_if.sv
// Handshake bundle for word_accum_rx: word input stream and block-sum output stream.
// The sum signal is named do_sum because "do" is a reserved word.
interface word_accum_rx_if
    import acc_pkg::*;
#(
    parameter int SW = SW_DEF
);

    logic [DW-1:0] di;
    logic          di_valid;
    logic          di_ready;
    logic [SW-1:0] do_sum;
    logic          do_valid;
    logic          do_ready;
    logic          ovf;

    // Environment side: produces words, consumes block sums.
    modport master (
        output di, di_valid, do_ready,
        input  di_ready, do_sum, do_valid, ovf
    );

    // Accumulator side.
    modport slave (
        input  di, di_valid, do_ready,
        output di_ready, do_sum, do_valid, ovf
    );

endinterface

// File: rtl/acc_add.sv
// SW+1-bit adder for the block accumulator: adds a zero-extended word to the
// running sum and reports the carry out of SW bits.
// With ACC_SAT_EN defined the result clamps to all-ones on carry; otherwise it wraps.
module acc_add
    import acc_pkg::*;
#(
    parameter int SW = SW_DEF
) (
    input  logic [SW-1:0] acc,
    input  logic [DW-1:0] di,
    output logic [SW-1:0] sum,
    output logic          carry
);

    logic [SW:0] full;

    // One extra bit captures the carry out of the SW-bit sum.
    always_comb begin
        full  = {1'b0, acc} + (SW + 1)'(di);
        carry = full[SW];
`ifdef ACC_SAT_EN
        sum   = carry ? '1 : full[SW-1:0];
`else
        sum   = full[SW-1:0];
`endif
    end

endmodule

// File: rtl/word_accum_rx.sv
// Receive-side block accumulator: sums COUNT 8-bit words accepted over a
// valid/ready handshake and presents the registered sum plus a carry flag.
// Optional saturation of the sum is selected by the ACC_SAT_EN macro (see acc_add).
module word_accum_rx
    import acc_pkg::*;
#(
    parameter int COUNT = COUNT_DEF,
    parameter int SW    = SW_DEF
) (
    input  logic          clk,
    input  logic          res,
    word_accum_rx_if.slave bus
);

    localparam logic [CW-1:0] LAST_CNT = CW'(COUNT - 1);

    state_t        state;
    state_t        state_nx;
    logic [SW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          ovf_r;
    logic [SW-1:0] add_sum;
    logic          add_carry;
    logic          in_xfer;
    logic          out_xfer;
    logic          last_word;

    assign in_xfer   = bus.di_valid && bus.di_ready;
    assign out_xfer  = bus.do_valid && bus.do_ready;
    assign last_word = (cnt == LAST_CNT);

    acc_add #(.SW(SW)) u_add (
        .acc   (acc),
        .di    (bus.di),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // State register; asynchronous reset returns to IDLE and drops any partial block.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge res) begin
        if (res) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next-state decode from the two handshakes.
    // NOTE: the default assignment up front keeps this block free of inferred latches.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (in_xfer) state_nx = (COUNT == 1) ? ST_OUT : ST_ACC;
            ST_ACC:  if (in_xfer && last_word) state_nx = ST_OUT;
            ST_OUT:  if (out_xfer) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Input ready decoded from the registered state only.
    always_comb begin
        bus.di_ready = (state != ST_OUT);
    end

    // Accumulator, counter and registered output stage.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            acc          <= '0;
            cnt          <= '0;
            ovf_r        <= 1'b0;
            bus.do_sum   <= '0;
            bus.ovf      <= 1'b0;
            bus.do_valid <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_xfer) begin
                        acc   <= SW'(bus.di);
                        cnt   <= CW'(1);
                        ovf_r <= 1'b0;
                        if (COUNT == 1) begin
                            bus.do_sum   <= SW'(bus.di);
                            bus.ovf      <= 1'b0;
                            bus.do_valid <= 1'b1;
                        end
                    end
                end
                ST_ACC: begin
                    if (in_xfer) begin
                        acc   <= add_sum;
                        ovf_r <= ovf_r | add_carry;
                        cnt   <= cnt + 1'b1;
                        if (last_word) begin
                            bus.do_sum   <= add_sum;
                            bus.ovf      <= ovf_r | add_carry;
                            bus.do_valid <= 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_xfer) bus.do_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_word_accum_rx.sv
// Directed bench for word_accum_rx: three instances (COUNT = 8, 32, 1; SW = 12)
// sharing clock and reset. Expected sums are hand-computed constants.
module tb_word_accum_rx;
    import acc_pkg::*;

    logic clk = 1'b0;
    logic res = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    word_accum_rx_if #(.SW(12)) a8  ();
    word_accum_rx_if #(.SW(12)) a32 ();
    word_accum_rx_if #(.SW(12)) a1  ();

    word_accum_rx #(.COUNT(8),  .SW(12)) u8  (.clk(clk), .res(res), .bus(a8));
    word_accum_rx #(.COUNT(32), .SW(12)) u32 (.clk(clk), .res(res), .bus(a32));
    word_accum_rx #(.COUNT(1),  .SW(12)) u1  (.clk(clk), .res(res), .bus(a1));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic rdy(input int unit);
        case (unit)
            8:       return a8.di_ready;
            32:      return a32.di_ready;
            default: return a1.di_ready;
        endcase
    endfunction

    function automatic logic vld(input int unit);
        case (unit)
            8:       return a8.do_valid;
            32:      return a32.do_valid;
            default: return a1.do_valid;
        endcase
    endfunction

    task automatic drive_di(input int unit, input logic [7:0] w, input logic v);
        case (unit)
            8:       begin a8.di  = w; a8.di_valid  = v; end
            32:      begin a32.di = w; a32.di_valid = v; end
            default: begin a1.di  = w; a1.di_valid  = v; end
        endcase
    endtask

    // Offer one word and return #1 after the edge that accepted it.
    task automatic put_word(input int unit, input logic [7:0] w);
        logic r;
        bit   ok;
        ok = 1'b0;
        drive_di(unit, w, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            r = rdy(unit);
            @(posedge clk);
            #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        drive_di(unit, 8'h00, 1'b0);
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL put_word unit %0d: di_ready stayed 0 for 20 cycles, required 1", unit);
        end
    endtask

    // Let the output be taken and wait until do_valid falls.
    task automatic drain(input int unit);
        bit ok;
        ok = 1'b0;
        case (unit)
            8:       a8.do_ready  = 1'b1;
            32:      a32.do_ready = 1'b1;
            default: a1.do_ready  = 1'b1;
        endcase
        for (int i = 0; i < 10; i++) begin
            if (!vld(unit)) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain unit %0d: do_valid stayed 1, required 0", unit);
        end
    endtask

    task automatic test_reset;
        #1 res = 1'b1;
        #1;
        n_cmp++; if (a8.do_sum !== 12'd0) begin n_bad++; $display("FAIL reset_do: got %0d want 0", a8.do_sum); end
        n_cmp++; if (a8.do_valid !== 1'b0) begin n_bad++; $display("FAIL reset_do_valid: got %b want 0", a8.do_valid); end
        n_cmp++; if (a8.ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", a8.ovf); end
        repeat (2) @(posedge clk);
        @(negedge clk) res = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (a8.di_ready !== 1'b1) begin n_bad++; $display("FAIL reset_di_ready: got %b want 1", a8.di_ready); end
        n_cmp++; if (a32.do_valid !== 1'b0 || a1.do_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_do_valid_others: got %b/%b want 0/0", a32.do_valid, a1.do_valid);
        end
    endtask

    task automatic test_back_to_back;
        a8.do_ready = 1'b1;
        for (int i = 1; i <= 7; i++) put_word(8, 8'(i));
        n_cmp++; if (a8.do_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_early_valid: got %b want 0", a8.do_valid); end
        put_word(8, 8'd8);
        n_cmp++; if (a8.do_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: got %b want 1", a8.do_valid); end
        n_cmp++; if (a8.do_sum !== 12'd36) begin n_bad++; $display("FAIL b2b_sum: got %0d want 36", a8.do_sum); end
        n_cmp++; if (a8.ovf !== 1'b0) begin n_bad++; $display("FAIL b2b_ovf: got %b want 0", a8.ovf); end
        n_cmp++; if (a8.di_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_out: got %b want 0", a8.di_ready); end
        @(posedge clk);
        #1;
        n_cmp++; if (a8.do_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_one_cycle: got %b want 0", a8.do_valid); end
        n_cmp++; if (a8.di_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_idle: got %b want 1", a8.di_ready); end
    endtask

    task automatic test_backpressure;
        a8.do_ready = 1'b0;
        for (int i = 1; i <= 8; i++) put_word(8, 8'(i));
        a8.di = 8'd99;
        a8.di_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (a8.do_sum !== 12'd36 || a8.do_valid !== 1'b1 || a8.di_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_cycle%0d: got do=%0d valid=%b ready=%b want 36/1/0",
                         c, a8.do_sum, a8.do_valid, a8.di_ready);
            end
        end
        a8.do_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (a8.do_valid !== 1'b0 || a8.di_ready !== 1'b1) begin
            n_bad++; $display("FAIL stall_release: got valid=%b ready=%b want 0/1", a8.do_valid, a8.di_ready);
        end
        put_word(8, 8'd99);
        for (int i = 0; i < 7; i++) put_word(8, 8'd1);
        n_cmp++; if (a8.do_sum !== 12'd106 || a8.do_valid !== 1'b1) begin
            n_bad++; $display("FAIL stall_next_block: got %0d valid=%b want 106 valid=1", a8.do_sum, a8.do_valid);
        end
        drain(8);
    endtask

    task automatic test_toggle;
        a8.do_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) begin
                @(posedge clk);
                #1;
            end
            put_word(8, 8'(i));
        end
        n_cmp++; if (a8.do_sum !== 12'd36 || a8.do_valid !== 1'b1) begin
            n_bad++; $display("FAIL toggle_sum: got %0d valid=%b want 36 valid=1", a8.do_sum, a8.do_valid);
        end
        drain(8);
    endtask

    task automatic test_ff_words;
        for (int i = 0; i < 8; i++) put_word(8, 8'hFF);
        n_cmp++; if (a8.do_sum !== 12'd2040) begin n_bad++; $display("FAIL ff_sum: got %0d want 2040", a8.do_sum); end
        n_cmp++; if (a8.ovf !== 1'b0) begin n_bad++; $display("FAIL ff_ovf: got %b want 0", a8.ovf); end
        drain(8);
    endtask

    // Leaves u32 holding its result in ST_OUT for the asynchronous reset test.
    task automatic test_overflow;
        logic [11:0] exp_sum;
`ifdef ACC_SAT_EN
        exp_sum = 12'd4095;
`else
        exp_sum = 12'd4064;
`endif
        a32.do_ready = 1'b0;
        for (int i = 0; i < 32; i++) put_word(32, 8'hFF);
        n_cmp++; if (a32.do_sum !== exp_sum) begin n_bad++; $display("FAIL ovf32_sum: got %0d want %0d", a32.do_sum, exp_sum); end
        n_cmp++; if (a32.ovf !== 1'b1) begin n_bad++; $display("FAIL ovf32_flag: got %b want 1", a32.ovf); end
        n_cmp++; if (a32.do_valid !== 1'b1) begin n_bad++; $display("FAIL ovf32_valid: got %b want 1", a32.do_valid); end
    endtask

    task automatic test_count_one;
        a1.do_ready = 1'b0;
        put_word(1, 8'h5A);
        n_cmp++; if (a1.do_valid !== 1'b1 || a1.do_sum !== 12'd90 || a1.ovf !== 1'b0) begin
            n_bad++; $display("FAIL count1_first: got valid=%b do=%0d ovf=%b want 1/90/0", a1.do_valid, a1.do_sum, a1.ovf);
        end
        n_cmp++; if (a1.di_ready !== 1'b0) begin n_bad++; $display("FAIL count1_ready: got %b want 0", a1.di_ready); end
        drain(1);
        put_word(1, 8'h03);
        n_cmp++; if (a1.do_valid !== 1'b1 || a1.do_sum !== 12'd3) begin
            n_bad++; $display("FAIL count1_second: got valid=%b do=%0d want 1/3", a1.do_valid, a1.do_sum);
        end
        drain(1);
    endtask

    task automatic test_reset_async;
        @(posedge clk);
        #3 res = 1'b1;
        #1;
        n_cmp++; if (a32.do_sum !== 12'd0 || a32.do_valid !== 1'b0 || a32.ovf !== 1'b0) begin
            n_bad++; $display("FAIL async_reset_out: got do=%0d valid=%b ovf=%b want 0/0/0", a32.do_sum, a32.do_valid, a32.ovf);
        end
        @(negedge clk) res = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (a32.di_ready !== 1'b1) begin n_bad++; $display("FAIL async_reset_ready: got %b want 1", a32.di_ready); end
        a32.do_ready = 1'b1;
    endtask

    task automatic test_reset_midblock;
        a8.do_ready = 1'b1;
        put_word(8, 8'd5);
        put_word(8, 8'd6);
        put_word(8, 8'd7);
        #2 res = 1'b1;
        @(negedge clk) res = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (a8.di_ready !== 1'b1 || a8.do_valid !== 1'b0) begin
            n_bad++; $display("FAIL midblock_after_reset: got ready=%b valid=%b want 1/0", a8.di_ready, a8.do_valid);
        end
        for (int i = 0; i < 8; i++) put_word(8, 8'd10);
        n_cmp++; if (a8.do_sum !== 12'd80 || a8.do_valid !== 1'b1 || a8.ovf !== 1'b0) begin
            n_bad++; $display("FAIL midblock_sum: got do=%0d valid=%b ovf=%b want 80/1/0", a8.do_sum, a8.do_valid, a8.ovf);
        end
        drain(8);
    endtask

    initial begin
        a8.di  = '0; a8.di_valid  = 1'b0; a8.do_ready  = 1'b1;
        a32.di = '0; a32.di_valid = 1'b0; a32.do_ready = 1'b1;
        a1.di  = '0; a1.di_valid  = 1'b0; a1.do_ready  = 1'b1;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_toggle();
        test_ff_words();
        test_overflow();
        test_count_one();
        test_reset_async();
        test_reset_midblock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
